// File: rtl/alu_muldiv_if.sv
// Request/response bus of the iterative multiply/divide unit.
// The master drives operations and consumes results; the slave is the unit.
interface alu_muldiv_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   rs1;
    logic [XLEN-1:0]   rs2;
    logic [TAG_W-1:0]  tag_in;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   rd;
    logic              z;
    logic [TAG_W-1:0]  tag_out;

    modport master (
        output in_valid, funct3, rs1, rs2, tag_in, out_ready,
        input  in_ready, out_valid, rd, z, tag_out
    );

    modport slave (
        input  in_valid, funct3, rs1, rs2, tag_in, out_ready,
        output in_ready, out_valid, rd, z, tag_out
    );
endinterface

// File: rtl/alu_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit.
// Multiply is radix-2 shift-add on operand magnitudes, divide is restoring
// division on magnitudes; signs are re-applied in a single fix-up cycle.
// hi/lo are shared: {hi,lo} is the product accumulator for multiplies and
// {remainder,quotient} for divides.
module alu_muldiv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    alu_muldiv_if.slave   bus
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t            state;
    logic [2:0]        op;
    logic [TAG_W-1:0]  tag_q;
    logic              neg;
    logic [XLEN-1:0]   opnd;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [CW-1:0]     count;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [XLEN-1:0]   rd_q;
    logic              z_q;
    logic [TAG_W-1:0]  tag_out_q;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.rd        = rd_q;
    assign bus.z         = z_q;
    assign bus.tag_out   = tag_out_q;

    // Request decode: operand magnitudes, result sign and special-case detection
    logic              a_signed, b_signed, rs1_neg, rs2_neg, neg_in;
    logic [XLEN-1:0]   rs1_mag, rs2_mag, spec_rd;
    logic              div_zero, div_ovf, special;
    always_comb begin
        a_signed = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b101) && (bus.funct3 != 3'b111);
        b_signed = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                   (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
        rs1_neg  = a_signed & bus.rs1[XLEN-1];
        rs2_neg  = b_signed & bus.rs2[XLEN-1];
        rs1_mag  = rs1_neg ? (~bus.rs1 + 1'b1) : bus.rs1;
        rs2_mag  = rs2_neg ? (~bus.rs2 + 1'b1) : bus.rs2;
        // Remainder follows the dividend; every other result follows the sign product
        neg_in   = (bus.funct3[2] & bus.funct3[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);
        div_zero = bus.funct3[2] && (bus.rs2 == '0);
        div_ovf  = bus.funct3[2] && !bus.funct3[0] && (bus.rs1 == MIN_NEG) && (bus.rs2 == '1);
        special  = div_zero | div_ovf;
        spec_rd  = '0;
        if (div_zero)
            spec_rd = bus.funct3[1] ? bus.rs1 : '1;
        else if (div_ovf)
            spec_rd = bus.funct3[1] ? '0 : bus.rs1;
    end

    // One iteration step: shift-add for multiply, trial subtract for divide
    logic [XLEN:0]     mul_sum, r_sh, diff;
    logic [XLEN-1:0]   calc_hi, calc_lo;
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        r_sh    = {hi, lo[XLEN-1]};
        diff    = r_sh - {1'b0, opnd};
        if (op[2]) begin
            if (!diff[XLEN]) begin
                calc_hi = diff[XLEN-1:0];
                calc_lo = {lo[XLEN-2:0], 1'b1};
            end else begin
                calc_hi = r_sh[XLEN-1:0];
                calc_lo = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            calc_hi = mul_sum[XLEN:1];
            calc_lo = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Sign correction and result selection
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_rd;
    always_comb begin
        prod   = {hi, lo};
        prod_s = neg ? (~prod + 1'b1) : prod;
        quo_s  = neg ? (~lo + 1'b1) : lo;
        rem_s  = neg ? (~hi + 1'b1) : hi;
        case (op)
            3'b000:                 fix_rd = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: fix_rd = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         fix_rd = quo_s;
            default:                fix_rd = rem_s;
        endcase
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            z_q         <= 1'b0;
            tag_out_q   <= '0;
            op          <= '0;
            tag_q       <= '0;
            neg         <= 1'b0;
            opnd        <= '0;
            hi          <= '0;
            lo          <= '0;
            count       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        op         <= bus.funct3;
                        tag_q      <= bus.tag_in;
                        neg        <= neg_in;
                        count      <= '0;
                        hi         <= '0;
                        in_ready_q <= 1'b0;
                        if (bus.funct3[2]) begin
                            opnd <= rs2_mag;
                            lo   <= rs1_mag;
                        end else begin
                            opnd <= rs1_mag;
                            lo   <= rs2_mag;
                        end
                        if (special) begin
                            rd_q        <= spec_rd;
                            z_q         <= (spec_rd == '0);
                            tag_out_q   <= bus.tag_in;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    hi    <= calc_hi;
                    lo    <= calc_lo;
                    count <= count + 1'b1;
                    if (count == CW'(XLEN-1))
                        state <= FIX;
                end
                FIX: begin
                    rd_q        <= fix_rd;
                    z_q         <= (fix_rd == '0);
                    tag_out_q   <= tag_q;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (XLEN=32) using an expected-result queue.
module tb_alu_muldiv;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    typedef struct {
        logic [31:0] rd;
        logic        z;
        logic [4:0]  tag;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_muldiv_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
    alu_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t sb[$];

    // Reference result computed from integer arithmetic
    function automatic logic [31:0] ref_rd(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb2;
        logic [63:0] ua, ub, w;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        ua  = {32'h0, a};
        ub  = {32'h0, b};
        case (f3)
            3'd0: begin w = ua * ub; return w[31:0]; end
            3'd1: begin w = sa * sb2; return w[63:32]; end
            3'd2: begin w = sa * longint'(ua); return w[63:32]; end
            3'd3: begin w = ua * ub; return w[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                w = sa / sb2; return w[31:0];
            end
            3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                w = sa % sb2; return w[31:0];
            end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && b == 0) return 1;
        if (f3[2] && !f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return XLEN + 2;
    endfunction

    function automatic exp_t mk_exp(input logic [31:0] r, input logic [4:0] t, input int l);
        exp_t e;
        e.rd = r; e.z = (r == 32'h0); e.tag = t; e.lat = l;
        return e;
    endfunction

    // Present one request for one edge; acc reports whether in_ready was high at that edge
    task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t, output logic acc);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.funct3   = f3;
        bus.rs1      = a;
        bus.rs2      = b;
        bus.tag_in   = t;
        acc          = bus.in_ready;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.rs1      = $urandom;
        bus.rs2      = $urandom;
        bus.tag_in   = 5'($urandom);
    endtask

    // Wait (bounded) for a result, capture it, then complete the output handshake
    task automatic collect(output int lat, output logic [31:0] r, output logic zz, output logic [4:0] t);
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        r  = bus.rd;
        zz = bus.z;
        t  = bus.tag_out;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.rd !== 32'h0) begin n_fail++; $display("FAIL reset_rd got %h want 0", bus.rd); end
        n_cmp++; if (bus.z !== 1'b0) begin n_fail++; $display("FAIL reset_z got %b want 0", bus.z); end
        n_cmp++; if (bus.tag_out !== 5'h0) begin n_fail++; $display("FAIL reset_tag got %h want 0", bus.tag_out); end
        rst = 1'b0;
    endtask

    // Run a table of operations with fixed expected results through the scoreboard
    task automatic test_table(input string name, input logic [2:0] f3s[8], input logic [31:0] as[8],
                              input logic [31:0] bs[8], input logic [31:0] rs[8], input int lats[8], input int n);
        logic acc; int lat; logic [31:0] r; logic zz; logic [4:0] t; exp_t e;
        for (int i = 0; i < n; i++) begin
            send(f3s[i], as[i], bs[i], 5'(i + 3), acc);
            sb.push_back(mk_exp(rs[i], 5'(i + 3), lats[i]));
            n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL %s_accept[%0d] got %b want 1", name, i, acc); end
            collect(lat, r, zz, t);
            e = sb.pop_front();
            n_cmp++; if (lat != e.lat) begin n_fail++; $display("FAIL %s_latency[%0d] got %0d want %0d", name, i, lat, e.lat); end
            n_cmp++; if (r !== e.rd) begin n_fail++; $display("FAIL %s_rd[%0d] got %h want %h", name, i, r, e.rd); end
            n_cmp++; if (zz !== e.z) begin n_fail++; $display("FAIL %s_z[%0d] got %b want %b", name, i, zz, e.z); end
            n_cmp++; if (t !== e.tag) begin n_fail++; $display("FAIL %s_tag[%0d] got %h want %h", name, i, t, e.tag); end
        end
    endtask

    task automatic test_mul();
        logic [2:0]  f3s[8] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0};
        logic [31:0] as[8]  = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0};
        logic [31:0] bs[8]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0};
        logic [31:0] rs[8]  = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 0, 0, 0, 0};
        int          ls[8]  = '{34, 34, 34, 34, 34, 34, 34, 34};
        test_table("mul", f3s, as, bs, rs, ls, 5);
    endtask

    task automatic test_div();
        logic [2:0]  f3s[8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd0, 3'd0, 3'd0};
        logic [31:0] as[8]  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd20, 32'd20, 32'd2, 0, 0, 0};
        logic [31:0] bs[8]  = '{32'd2, 32'd2, 32'd3, 32'd3, 32'd3, 0, 0, 0};
        logic [31:0] rs[8]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd6, 32'd2, 32'd0, 0, 0, 0};
        int          ls[8]  = '{34, 34, 34, 34, 34, 34, 34, 34};
        test_table("div", f3s, as, bs, rs, ls, 5);
    endtask

    task automatic test_special();
        logic [2:0]  f3s[8] = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd4};
        logic [31:0] as[8]  = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd9, 32'd9, 32'h8000_0000, 32'h8000_0001};
        logic [31:0] bs[8]  = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] rs[8]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'd9, 32'd0, 32'h7FFF_FFFF};
        int          ls[8]  = '{1, 1, 1, 1, 1, 1, 34, 34};
        test_table("special", f3s, as, bs, rs, ls, 8);
    endtask

    task automatic test_backpressure();
        logic acc; int lat; exp_t e; logic seen;
        send(3'd0, 32'd3, 32'd5, 5'd9, acc);
        sb.push_back(mk_exp(32'd15, 5'd9, 34));
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 200) begin @(negedge clk); lat++; end
        e = sb.pop_front();
        n_cmp++; if (lat != e.lat) begin n_fail++; $display("FAIL bp_latency got %0d want %0d", lat, e.lat); end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i == 3 || i == 4);
            bus.funct3   = 3'd5;
            bus.rs1      = 32'd100;
            bus.rs2      = 32'd7;
            bus.tag_in   = 5'd21;
            @(negedge clk);
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b want 1", i, bus.out_valid); end
            n_cmp++; if (bus.rd !== e.rd) begin n_fail++; $display("FAIL bp_rd[%0d] got %h want %h", i, bus.rd, e.rd); end
            n_cmp++; if (bus.tag_out !== e.tag) begin n_fail++; $display("FAIL bp_tag[%0d] got %h want %h", i, bus.tag_out, e.tag); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, bus.in_ready); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_handshake_in_ready got %b want 0", bus.in_ready); end
        @(negedge clk);
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_in_ready got %b want 1", bus.in_ready); end
        seen = 1'b0;
        repeat (40) begin @(negedge clk); if (bus.out_valid === 1'b1) seen = 1'b1; end
        n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_request got %b want 0", seen); end
    endtask

    task automatic test_reset_midcalc();
        logic acc; int lat; logic [31:0] r; logic zz; logic [4:0] t; exp_t e;
        send(3'd0, 32'd1234, 32'd5678, 5'd17, acc);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstcalc_out_valid got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstcalc_in_ready got %b want 1", bus.in_ready); end
        send(3'd0, 32'd3, 32'd4, 5'd2, acc);
        sb.push_back(mk_exp(32'd12, 5'd2, 34));
        collect(lat, r, zz, t);
        e = sb.pop_front();
        n_cmp++; if (lat != e.lat) begin n_fail++; $display("FAIL rstcalc_latency got %0d want %0d", lat, e.lat); end
        n_cmp++; if (r !== e.rd) begin n_fail++; $display("FAIL rstcalc_rd got %h want %h", r, e.rd); end
        n_cmp++; if (t !== e.tag) begin n_fail++; $display("FAIL rstcalc_tag got %h want %h", t, e.tag); end
    endtask

    task automatic test_back_to_back();
        logic acc; int lat; logic [31:0] r; logic zz; logic [4:0] t; exp_t e;
        logic [2:0] f3; logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (i % 5 == 0) b = 32'h0;
            if (i % 4 == 1) a = a >> $urandom_range(0, 31);
            if (i % 3 == 2) b = b >> $urandom_range(0, 31);
            if (i == 7) begin f3 = 3'd6; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            send(f3, a, b, 5'(i), acc);
            sb.push_back(mk_exp(ref_rd(f3, a, b), 5'(i), ref_lat(f3, a, b)));
            n_cmp++; if (acc !== 1'b1) begin n_fail++; $display("FAIL b2b_accept[%0d] got %b want 1", i, acc); end
            collect(lat, r, zz, t);
            e = sb.pop_front();
            n_cmp++; if (lat != e.lat) begin n_fail++; $display("FAIL b2b_latency[%0d] f3=%0d got %0d want %0d", i, f3, lat, e.lat); end
            n_cmp++; if (r !== e.rd) begin n_fail++; $display("FAIL b2b_rd[%0d] f3=%0d a=%h b=%h got %h want %h", i, f3, a, b, r, e.rd); end
            n_cmp++; if (zz !== e.z) begin n_fail++; $display("FAIL b2b_z[%0d] got %b want %b", i, zz, e.z); end
            n_cmp++; if (t !== e.tag) begin n_fail++; $display("FAIL b2b_tag[%0d] got %h want %h", i, t, e.tag); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.funct3    = 3'd0;
        bus.rs1       = 32'h0;
        bus.rs2       = 32'h0;
        bus.tag_in    = 5'h0;
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_backpressure();
        test_reset_midcalc();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
